// File: rtl/csr_unit.sv
// Machine-mode CSR responder for the RV32I pipeline: combinational read, clocked write,
// 64-bit mcycle/minstret counters, trap entry and mret with the fetch redirect target.
module csr_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int unsigned HART_ID     = 0,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_en,
    input  logic [2:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_src,
    input  logic        src_is_zero,
    output logic [31:0] csr_rdata,
    output logic        illegal_csr,
    input  logic        retire,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        mie_o
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MINSTH   = 12'hB82;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;
    localparam logic [11:0] A_INSTRET  = 12'hC02;
    localparam logic [11:0] A_INSTRETH = 12'hC82;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    logic        r_mie;
    logic        r_mpie;
    logic [31:2] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:2] r_mepc;
    logic [31:0] r_mcause;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    logic [31:0] w_old;
    logic        w_mapped;
    logic        w_read_only;
    logic        w_wants_write;
    logic        w_illegal;
    logic        w_we;
    logic [31:0] w_wval;
    logic [2:0]  w_unused;

    assign w_unused = {csr_op[2], trap_pc[1:0]};

    always_comb begin
        w_old    = '0;
        w_mapped = 1'b1;
        case (csr_addr)
            A_MSTATUS:              w_old = {24'b0, r_mpie, 3'b0, r_mie, 3'b0};
            A_MISA:                 w_old = MISA_VAL;
            A_MTVEC:                w_old = {r_mtvec, 2'b00};
            A_MSCRATCH:             w_old = r_mscratch;
            A_MEPC:                 w_old = {r_mepc, 2'b00};
            A_MCAUSE:               w_old = r_mcause;
            A_MCYCLE, A_CYCLE:      w_old = r_mcycle[31:0];
            A_MCYCLEH, A_CYCLEH:    w_old = r_mcycle[63:32];
            A_MINSTRET, A_INSTRET:  w_old = r_minstret[31:0];
            A_MINSTH, A_INSTRETH:   w_old = r_minstret[63:32];
            A_MHARTID:              w_old = 32'(HART_ID);
            default:                w_mapped = 1'b0;
        endcase
    end

    always_comb begin
        w_wval        = w_old;
        w_wants_write = 1'b0;
        case (csr_op[1:0])
            2'b01: begin
                w_wval        = csr_src;
                w_wants_write = 1'b1;
            end
            2'b10: begin
                w_wval        = w_old | csr_src;
                w_wants_write = ~src_is_zero;
            end
            2'b11: begin
                w_wval        = w_old & ~csr_src;
                w_wants_write = ~src_is_zero;
            end
            default: begin
                w_wval        = w_old;
                w_wants_write = 1'b0;
            end
        endcase
    end

    assign w_read_only = (csr_addr[11:10] == 2'b11);
    assign w_illegal   = csr_en & (~w_mapped | (w_read_only & w_wants_write));
    // Trap and mret both pre-empt any CSR write issued in the same cycle.
    assign w_we        = csr_en & w_wants_write & ~w_illegal & ~trap_req & ~mret;

    assign csr_rdata   = csr_en ? w_old : '0;
    assign illegal_csr = w_illegal;
    assign redirect    = trap_req | mret;
    assign redirect_pc = trap_req ? {r_mtvec, 2'b00} : {r_mepc, 2'b00};
    assign mie_o       = r_mie;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= MTVEC_RESET[31:2];
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
        end else if (trap_req) begin
            r_mepc   <= trap_pc[31:2];
            r_mcause <= trap_cause;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_we) begin
            case (csr_addr)
                A_MSTATUS: begin
                    r_mie  <= w_wval[3];
                    r_mpie <= w_wval[7];
                end
                A_MTVEC:    r_mtvec    <= w_wval[31:2];
                A_MSCRATCH: r_mscratch <= w_wval;
                A_MEPC:     r_mepc     <= w_wval[31:2];
                A_MCAUSE:   r_mcause   <= w_wval;
                default: ;
            endcase
        end
    end

    // A write to either half replaces that cycle's increment of the whole counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_we && csr_addr == A_MCYCLE)
                r_mcycle <= {r_mcycle[63:32], w_wval};
            else if (w_we && csr_addr == A_MCYCLEH)
                r_mcycle <= {w_wval, r_mcycle[31:0]};
            else
                r_mcycle <= r_mcycle + 64'd1;

            if (w_we && csr_addr == A_MINSTRET)
                r_minstret <= {r_minstret[63:32], w_wval};
            else if (w_we && csr_addr == A_MINSTH)
                r_minstret <= {w_wval, r_minstret[31:0]};
            else if (retire)
                r_minstret <= r_minstret + 64'd1;
        end
    end

endmodule
